// File: rtl/pc_unit_pkg.sv
// Shared types and defaults for the program-counter stage.
package pc_pkg;

  localparam int PC_N = 16;
  localparam logic [PC_N-1:0] PC_INC = 16'd1;
  localparam logic [PC_N-1:0] PC_RESET_PC = 16'h0000;
  localparam int PC_RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    SEQ    = 2'b00,
    BRANCH = 2'b01,
    JUMP   = 2'b10,
    RET    = 2'b11
  } pc_sel_t;

endpackage

// File: rtl/pc_unit_if.sv
// Control/address bundle between the next-PC controller (master) and pc_unit (slave).
// All control inputs are sampled on the rising clk edge when stall=0; there is no
// valid/ready pair: every non-stalled cycle is an accepted transfer.
interface pc_unit_if import pc_pkg::*; #(
  parameter int N = PC_N
) ();

  logic          stall;
  pc_sel_t       pc_sel;
  logic          branch_taken;
  logic          call;
  logic [N-1:0]  branch_offset;
  logic [N-1:0]  jump_target;
  logic [N-1:0]  pc;
  logic [N-1:0]  pc_plus;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_err;

  modport master (
    output stall, pc_sel, branch_taken, call, branch_offset, jump_target,
    input  pc, pc_plus, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, pc_sel, branch_taken, call, branch_offset, jump_target,
    output pc, pc_plus, ras_empty, ras_full, ras_err
  );

endinterface

// File: rtl/adder.sv
// Plain N-bit modulo adder shared by the PC-increment and branch-target paths.
module adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_unit_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ras #(
  parameter int DEPTH = 4,
  parameter int N     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] din,
  output logic [N-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         overflow,
  output logic         underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  mem_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // ptr_q is the next free slot; the top of stack sits one below it.
  assign top       = mem_q[ptr_q - PW'(1)];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign overflow  = push & full;
  assign underflow = pop & empty;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[ptr_q] = din;
      ptr_d        = ptr_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: registered PC, next-PC select, and call/return stack.
module pc_unit import pc_pkg::*; #(
  parameter int           N        = PC_N,
  parameter logic [N-1:0] INC      = PC_INC,
  parameter logic [N-1:0] RESET_PC = PC_RESET_PC,
  parameter int           DEPTH    = PC_RAS_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  pc_unit_if.slave  bus
);

  logic [N-1:0] pc_q, pc_d;
  logic         err_q, err_d;
  logic [N-1:0] pc_plus;
  logic [N-1:0] branch_sum;
  logic [N-1:0] ras_top;
  logic         ras_push, ras_pop;
  logic         ras_empty, ras_full, ras_ovf, ras_unf;

  adder #(.N(N)) u_inc_add (
    .a   (pc_q),
    .b   (INC),
    .sum (pc_plus)
  );

  adder #(.N(N)) u_br_add (
    .a   (pc_plus),
    .b   (bus.branch_offset),
    .sum (branch_sum)
  );

  ras #(.DEPTH(DEPTH), .N(N)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .din       (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_ovf),
    .underflow (ras_unf)
  );

  // Stack requests are only raised in non-stalled cycles, so overflow and
  // underflow already carry the stall qualification.
  always_comb begin
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (!bus.stall) begin
      unique case (bus.pc_sel)
        SEQ:    pc_d = pc_plus;
        BRANCH: pc_d = bus.branch_taken ? branch_sum : pc_plus;
        JUMP: begin
          pc_d     = bus.jump_target;
          ras_push = bus.call;
        end
        RET: begin
          ras_pop = 1'b1;
          pc_d    = ras_empty ? pc_plus : ras_top;
        end
        default: pc_d = pc_plus;
      endcase
    end
  end

  assign err_d = err_q | ras_ovf | ras_unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus   = pc_plus;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table plus reset/stall corner sequences.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int W = 19;

  typedef struct {
    logic        stall;
    pc_sel_t     sel;
    logic        taken;
    logic        call;
    logic [15:0] off;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    logic        e_empty;
    logic        e_full;
    logic        e_err;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  vec_t vecs[$];
  logic [W-1:0] exp_q[$];

  pc_unit_if #(.N(16)) bus ();

  pc_unit #(.N(16), .INC(16'd1), .RESET_PC(16'h0000), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add_vec(input logic stall, input pc_sel_t sel, input logic taken,
                         input logic call, input logic [15:0] off, input logic [15:0] tgt,
                         input logic [15:0] e_pc, input logic e_empty, input logic e_full,
                         input logic e_err);
    vec_t v;
    v.stall = stall; v.sel = sel; v.taken = taken; v.call = call;
    v.off = off; v.tgt = tgt; v.e_pc = e_pc;
    v.e_empty = e_empty; v.e_full = e_full; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  // scoreboard: pop one expectation and compare it with what the DUT shows now
  task automatic score(input string tag);
    logic [W-1:0] e;
    logic [15:0]  e_plus;
    if (exp_q.size() == 0) begin
      check({tag, "/queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    e_plus = e[18:3] + 16'd1;
    check({tag, "/pc"}, {16'd0, bus.pc}, {16'd0, e[18:3]});
    check({tag, "/pc_plus"}, {16'd0, bus.pc_plus}, {16'd0, e_plus});
    check({tag, "/flags"}, {29'd0, bus.ras_empty, bus.ras_full, bus.ras_err},
          {29'd0, e[2:0]});
  endtask

  // driver: present inputs, record expectation, clock once, score
  task automatic apply(input vec_t v, input string tag);
    bus.stall         = v.stall;
    bus.pc_sel        = v.sel;
    bus.branch_taken  = v.taken;
    bus.call          = v.call;
    bus.branch_offset = v.off;
    bus.jump_target   = v.tgt;
    exp_q.push_back({v.e_pc, v.e_empty, v.e_full, v.e_err});
    @(posedge clk);
    #1;
    score(tag);
  endtask

  task automatic step(input logic stall, input pc_sel_t sel, input logic call,
                      input logic [15:0] tgt, input logic [15:0] e_pc, input logic e_empty,
                      input logic e_err, input string tag);
    vec_t v;
    v.stall = stall; v.sel = sel; v.taken = 1'b0; v.call = call;
    v.off = 16'h0; v.tgt = tgt; v.e_pc = e_pc;
    v.e_empty = e_empty; v.e_full = 1'b0; v.e_err = e_err;
    apply(v, tag);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.stall = 1'b0; bus.pc_sel = SEQ; bus.branch_taken = 1'b0; bus.call = 1'b0;
    bus.branch_offset = 16'h0; bus.jump_target = 16'h0;

    // vector table, starting from pc=0 with an empty stack
    for (int i = 0; i < 3; i++) add_vec(0, SEQ, 0, 0, 16'h0, 16'h0, 16'(i + 1), 1, 0, 0);
    add_vec(0, JUMP,   0, 0, 16'h0000, 16'h0010, 16'h0010, 1, 0, 0);
    add_vec(0, BRANCH, 1, 0, 16'hFFFB, 16'h0000, 16'h000C, 1, 0, 0);
    add_vec(0, JUMP,   0, 0, 16'h0000, 16'h0010, 16'h0010, 1, 0, 0);
    add_vec(0, BRANCH, 0, 0, 16'hFFFB, 16'h0000, 16'h0011, 1, 0, 0);
    add_vec(0, SEQ,    1, 0, 16'h0100, 16'h0000, 16'h0012, 1, 0, 0);
    add_vec(0, BRANCH, 1, 0, 16'h0005, 16'h0000, 16'h0018, 1, 0, 0);
    add_vec(0, JUMP,   0, 0, 16'h0000, 16'hFFFF, 16'hFFFF, 1, 0, 0);
    add_vec(0, SEQ,    0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
    add_vec(0, JUMP,   0, 0, 16'h0000, 16'h0020, 16'h0020, 1, 0, 0);
    add_vec(0, JUMP,   0, 1, 16'h0000, 16'h0100, 16'h0100, 0, 0, 0);
    add_vec(0, RET,    0, 0, 16'h0000, 16'h0000, 16'h0021, 1, 0, 0);
    add_vec(0, BRANCH, 1, 1, 16'h0000, 16'h0000, 16'h0022, 1, 0, 0);
    add_vec(0, JUMP,   0, 0, 16'h0000, 16'h0200, 16'h0200, 1, 0, 0);
    for (int k = 1; k <= 5; k++)
      add_vec(0, JUMP, 0, 1, 16'h0, 16'(16'h0200 + k * 16'h0100),
              16'(16'h0200 + k * 16'h0100), 0, (k >= 4), (k == 5));
    for (int k = 5; k >= 2; k--)
      add_vec(0, RET, 0, 0, 16'h0, 16'h0, 16'(16'h0101 + k * 16'h0100), (k == 2), 0, 1);
    add_vec(0, RET,    0, 0, 16'h0000, 16'h0000, 16'h0302, 1, 0, 1);
    for (int i = 0; i < 3; i++) add_vec(1, JUMP, 0, 1, 16'h0, 16'h0800, 16'h0302, 1, 0, 1);
    add_vec(0, JUMP,   0, 1, 16'h0000, 16'h0800, 16'h0800, 0, 0, 1);
    add_vec(1, RET,    0, 0, 16'h0000, 16'h0000, 16'h0800, 0, 0, 1);
    add_vec(0, RET,    0, 0, 16'h0000, 16'h0000, 16'h0303, 1, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_pc", {16'd0, bus.pc}, 32'h0000);

    // set ras_err and move pc to 0x40, then hit reset mid-cycle
    step(0, RET,  0, 16'h0000, 16'h0001, 1, 1, "pre_underflow");
    step(0, JUMP, 0, 16'h0040, 16'h0040, 1, 1, "pre_jump40");
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_pc", {16'd0, bus.pc}, 32'h0000);
    check("async_rst_pc_plus", {16'd0, bus.pc_plus}, 32'h0001);
    check("async_rst_flags", {29'd0, bus.ras_empty, bus.ras_full, bus.ras_err}, 32'b100);
    @(posedge clk);
    #1;
    check("rst_held_pc", {16'd0, bus.pc}, 32'h0000);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // reset asserted while stalled overrides the held state
    step(1, JUMP, 1, 16'h0900, 16'h0303, 1, 1, "stall_pre_rst");
    #3;
    rst = 1'b1;
    #1;
    check("stall_rst_pc", {16'd0, bus.pc}, 32'h0000);
    check("stall_rst_flags", {29'd0, bus.ras_empty, bus.ras_full, bus.ras_err}, 32'b100);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, RET, 0, 16'h0000, 16'h0000, 1, 0, "stall_ret_no_err");
    step(0, SEQ, 0, 16'h0000, 16'h0001, 1, 0, "post_rst_seq");

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, tests run %0d", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the 16-bit single-cycle CPU. It holds the current instruction address, drives the 16-bit adder's operand path that forms the sequential and branch addresses, and consumes those sums to select the next PC. It also maintains a small return-address stack for call/return. It sits directly upstream of instruction memory and is the producer and consumer of the PC-increment and branch-target adders.

## Interface
- N, 16, address/data width
- INC, 1, sequential increment (word-addressed instruction memory)
- RESET_PC, 16'h0000, PC value loaded on reset
- DEPTH, 4, return-address-stack entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and stack this cycle
- pc_sel  in  2  next-PC source: SEQ=00, BRANCH=01, JUMP=10, RET=11
- branch_taken  in  1  qualifies BRANCH; ignored otherwise
- call  in  1  with JUMP, push return address; ignored with other selects
- branch_offset  in  N  two's-complement offset, relative to pc_plus
- jump_target  in  N  absolute target for JUMP
- pc  out  N  current PC (registered)
- pc_plus  out  N  pc + INC (combinational), also the link value
- ras_empty  out  1  stack holds no entries
- ras_full  out  1  stack holds DEPTH entries
- ras_err  out  1  sticky: overflow or underflow occurred since reset

## Operation
- Single clock `clk`; asynchronous active-high reset `rst`.
- Reset, asynchronous and immediate: pc=RESET_PC, stack count=0, ras_err=0. So ras_empty=1, ras_full=0, pc_plus=RESET_PC+INC.
- Next PC is evaluated each cycle with stall=0:
  - SEQ: pc_plus.
  - BRANCH: pc_plus + branch_offset if branch_taken, else pc_plus.
  - JUMP: jump_target. If call=1, pc_plus is pushed.
  - RET: top of stack, which is popped. If the stack is empty, next PC = pc_plus, the stack is unchanged, and ras_err is set.
- Arithmetic is modulo 2^N, with wrap-around and no carry out. For example, 16'hFFFF + INC = 16'h0000.
- Push when full: the oldest entry is overwritten (circular buffer), count stays DEPTH, and ras_err is set.
- stall=1: pc, stack and ras_err all hold. pc_sel, call and branch_taken are ignored.
- ras_err clears only on rst.

## Timing
- pc updates on the rising clk edge. The selected next PC is visible on pc one cycle after inputs are sampled.
- pc_plus, ras_empty and ras_full follow pc and stack state combinationally. There is no extra latency.
- Push and pop take effect on the same edge as the PC update. A popped value is used as the next PC at that edge; there is no read-after-write bypass.
- Back-to-back JUMP+call followed by RET on the next cycle returns to the address after the call.
- rst asserted mid-stall or mid-sequence overrides everything asynchronously. The first post-reset edge with stall=0 loads RESET_PC+INC (for SEQ).

## Structure
- Shared package `pc_pkg` contains:
  - enum `pc_sel_t` (SEQ, BRANCH, JUMP, RET)
  - width constant
  - default INC and RESET_PC localparams
- One sub-module, `ras`:
  - parametrized DEPTH×N circular stack
  - inputs push, pop, din; outputs top, empty, full, overflow, underflow
  - owns its pointer and count registers
- `pc_unit` instantiates `ras` and uses the existing `adder` for pc+INC and pc_plus+branch_offset.

## Test plan
- Reset: assert rst mid-cycle with pc=16'h0040 -> pc=16'h0000 immediately, ras_empty=1, ras_err=0. Then 3 SEQ cycles -> pc = 1, 2, 3.
- Branch: pc=16'h0010, BRANCH, branch_taken=1, offset=16'hFFFB (-5) -> pc=16'h000C. Same with branch_taken=0 -> pc=16'h0011.
- Wrap: pc=16'hFFFF, SEQ -> pc=16'h0000.
- Call/return: pc=16'h0020, JUMP call=1, target=16'h0100 -> pc=16'h0100, ras_empty=0. Then RET -> pc=16'h0021, ras_empty=1.
- Stack limits:
  - 5 nested calls with DEPTH=4 -> ras_full=1 and ras_err=1. Four RETs then return to the 5th, 4th, 3rd and 2nd link addresses.
  - A further RET on the empty stack -> pc=pc_plus and ras_err stays 1.
- Stall: with stall=1 for 3 cycles during JUMP call=1 -> pc, stack and ras_empty unchanged. Deasserting stall -> the jump and push occur on the next edge.
